// File: rtl/apb_arb_pkg.sv
// Shared types and sizing helpers for the APB master arbiter.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int NUM_REQ_MAX = 8;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // A timeout of 0 still needs a 1-bit counter so the port widths stay legal.
   function automatic int cnt_w(input int t);
      return (t > 0) ? $clog2(t + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping.
module rr_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int PW = ptr_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PW-1:0]      gnt_idx_o,
   output logic               any_gnt_o
);

   int idx;

   // Scan from farthest to nearest so the last hit written is the closest to ptr_i.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      any_gnt_o = 1'b0;
      idx       = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = (int'(ptr_i) + i) % NUM_REQ;
         if (req_i[idx]) begin
            gnt_o      = '0;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = PW'(idx);
            any_gnt_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin share of one APB master port among NUM_REQ requesters,
// sequencing SETUP/ACCESS and returning read data / error to the winner.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int ADDR_W      = `APB_ADDR_WIDTH,
   parameter int DATA_W      = `APB_DATA_WIDTH,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic [NUM_REQ-1:0]        REQ_VALID,
   input  logic [NUM_REQ-1:0]        REQ_WRITE,
   input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
   input  logic [NUM_REQ*DATA_W-1:0] REQ_WDATA,
   output logic [NUM_REQ-1:0]        REQ_READY,
   output logic [NUM_REQ-1:0]        RSP_VALID,
   output logic [DATA_W-1:0]         RSP_RDATA,
   output logic                      RSP_ERR,
   output logic [ADDR_W-1:0]         PADDR,
   output logic                      PWRITE,
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic [DATA_W-1:0]         PWDATA,
   input  logic [DATA_W-1:0]         PRDATA,
   input  logic                      PREADY,
   input  logic                      TrFr,
   output logic [1:0]                dbg_state_o
);

   localparam int PW = ptr_w(NUM_REQ);
   localparam int CW = cnt_w(TIMEOUT_CYC);

   apb_state_e           state_q;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [PW-1:0]        gidx_q;
   logic [CW-1:0]        wait_q, wait_d;
   logic [NUM_REQ-1:0]   gnt;
   logic [PW-1:0]        gnt_idx;
   logic                 any_gnt;
   logic                 timeout_hit;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req_i     (REQ_VALID),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_gnt_o (any_gnt)
   );

   // Handshake: a request is taken in the cycle REQ_VALID[g] && REQ_READY[g];
   // its fields are sampled only then. RSP_VALID[g] pulses once per taken request.
   assign REQ_READY   = (state_q == ST_IDLE && !PRESET) ? gnt : '0;
   assign dbg_state_o = state_q;

   assign ptr_d       = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
   assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_q == CW'(TIMEOUT_CYC));
   assign wait_d      = (wait_q == CW'(TIMEOUT_CYC)) ? wait_q : wait_q + 1'b1;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gidx_q    <= '0;
         wait_q    <= '0;
         RSP_VALID <= '0;
         RSP_RDATA <= '0;
         RSP_ERR   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWDATA    <= '0;
      end else begin
         RSP_VALID <= '0;
         case (state_q)
            ST_IDLE: begin
               if (any_gnt) begin
                  PADDR   <= REQ_ADDR[gnt_idx*ADDR_W +: ADDR_W];
                  PWDATA  <= REQ_WDATA[gnt_idx*DATA_W +: DATA_W];
                  PWRITE  <= REQ_WRITE[gnt_idx];
                  gidx_q  <= gnt_idx;
                  ptr_q   <= ptr_d;
                  wait_q  <= '0;
                  PSEL    <= 1'b1;
                  state_q <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               PENABLE <= 1'b1;
               state_q <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // A ready slave beats a simultaneous timeout.
               if (PREADY) begin
                  RSP_VALID         <= '0;
                  RSP_VALID[gidx_q] <= 1'b1;
                  RSP_RDATA         <= PWRITE ? '0 : PRDATA;
                  RSP_ERR           <= TrFr;
                  PSEL              <= 1'b0;
                  PENABLE           <= 1'b0;
                  state_q           <= ST_IDLE;
               end else if (timeout_hit) begin
                  RSP_VALID         <= '0;
                  RSP_VALID[gidx_q] <= 1'b1;
                  RSP_RDATA         <= '0;
                  RSP_ERR           <= 1'b1;
                  PSEL              <= 1'b0;
                  PENABLE           <= 1'b0;
                  state_q           <= ST_IDLE;
               end else begin
                  wait_q <= wait_d;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
